// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge
// Instruction-fetch bridge: SRAM-like responder (req/addr_ok/data_ok) on the
// fetch side and a single-beat, single-ID AXI4 read master on the memory side.
// Each accepted fetch becomes one AR transfer. Returned words are handed back
// in order, one data_ok pulse per beat. The number of reads in flight is
// bounded by OUTSTANDING.

module inst_axi_bridge #(
    parameter int unsigned OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL    = 4'd0
) (
    input  logic        clk,
    input  logic        rstn,

    // fetch-side SRAM-like port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    // AXI4 read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    // AXI4 read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        bus_err
);

    localparam logic [3:0] OUTSTANDING_LIM = 4'(OUTSTANDING);

    logic [3:0]  cnt;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic [1:0]  size_q;
    logic        data_ok_q;
    logic [31:0] rdata_q;
    logic        bus_err_q;

    logic        accept;
    logic        r_hs;
    logic        r_take;
    logic        r_spurious;

    // Write-side and ID/last inputs carry no information for a read-only,
    // single-ID, single-beat fetch path; fold them into one sink signal.
    logic        unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast};

    // rready follows reset so the bridge never sinks beats while held in reset.
    assign rready = rstn;

    // A slot freed by an R beat this cycle is only visible next cycle, which
    // keeps addr_ok a function of registered state plus the live request.
    assign accept = rstn & inst_sram_req & (~arvalid_q | arready) & (cnt < OUTSTANDING_LIM);

    assign r_hs       = rvalid & rready;
    assign r_take     = r_hs & (cnt != 4'd0);
    assign r_spurious = r_hs & (cnt == 4'd0);

    assign inst_sram_addr_ok = accept;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;

    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;

    assign bus_err = bus_err_q;

    // Outstanding-read counter: +1 on acceptance, -1 on a consumed beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 4'd0;
        end else if (accept && !r_take) begin
            cnt <= cnt + 4'd1;
        end else if (r_take && !accept) begin
            cnt <= cnt - 4'd1;
        end
    end

    // AR channel: load on acceptance, hold while stalled, drop after handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arvalid_q <= 1'b0;
            araddr_q  <= 32'd0;
            size_q    <= 2'd0;
        end else if (accept) begin
            arvalid_q <= 1'b1;
            araddr_q  <= inst_sram_addr;
            size_q    <= inst_sram_size;
        end else if (arready) begin
            arvalid_q <= 1'b0;
        end
    end

    // Return path: register each consumed beat into a one-cycle data_ok pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            data_ok_q <= r_take;
            if (r_take) begin
                rdata_q <= rdata;
            end
        end
    end

    // Sticky error: error response on a real beat, or any beat with nothing in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_err_q <= 1'b0;
        end else if ((r_take && (rresp != 2'b00)) || r_spurious) begin
            bus_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// tb_inst_axi_bridge
// Directed bench for inst_axi_bridge. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge of the same cycle.

module tb_inst_axi_bridge;

    logic        clk;
    logic        rstn;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        bus_err;

    int n_vec;
    int n_err;

    inst_axi_bridge #(
        .OUTSTANDING (2),
        .ARID_VAL    (4'd0)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready),
        .bus_err           (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        chk({tag, "_araddr"},  araddr, 32'd0);
        chk({tag, "_arsize"},  32'(arsize), 32'd0);
        chk({tag, "_data_ok"}, 32'(inst_sram_data_ok), 32'd0);
        chk({tag, "_rdata"},   inst_sram_rdata, 32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, "_addr_ok"}, 32'(inst_sram_addr_ok), 32'd0);
        chk({tag, "_rready"},  32'(rready), 32'd0);
    endtask

    // Accept at T, AR at T+1, R beat at T+2, data_ok at T+3.
    task automatic single_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        tick();
        inst_sram_req  = 1'b1;
        inst_sram_addr = a;
        arready        = 1'b1;
        rvalid         = 1'b0;
        @(negedge clk);
        chk("sr_addr_ok_T", 32'(inst_sram_addr_ok), 32'd1);
        chk("sr_rready", 32'(rready), 32'd1);
        tick();
        inst_sram_req = 1'b0;
        @(negedge clk);
        chk("sr_arvalid_T1", 32'(arvalid), 32'd1);
        chk("sr_araddr_T1", araddr, a);
        chk("sr_arlen", 32'(arlen), 32'd0);
        chk("sr_arsize", 32'(arsize), 32'd2);
        chk("sr_arburst", 32'(arburst), 32'd1);
        chk("sr_arid", 32'(arid), 32'd0);
        tick();
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        @(negedge clk);
        chk("sr_data_ok_T2", 32'(inst_sram_data_ok), 32'd0);
        chk("sr_arvalid_T2", 32'(arvalid), 32'd0);
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
        @(negedge clk);
        chk("sr_data_ok_T3", 32'(inst_sram_data_ok), 32'd1);
        chk("sr_rdata_T3", inst_sram_rdata, d);
        tick();
        @(negedge clk);
        chk("sr_data_ok_T4", 32'(inst_sram_data_ok), 32'd0);
    endtask

    task automatic sync_reset();
        tick();
        rstn          = 1'b0;
        inst_sram_req = 1'b0;
        rvalid        = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn            = 1'b0;
        inst_sram_req   = 1'b0;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'b10;
        inst_sram_wstrb = 4'h0;
        inst_sram_addr  = 32'd0;
        inst_sram_wdata = 32'd0;
        arready         = 1'b0;
        rid             = 4'd0;
        rdata           = 32'd0;
        rresp           = 2'b00;
        rlast           = 1'b1;
        rvalid          = 1'b0;

        // power-on reset values, with a request pending to prove addr_ok is gated
        inst_sram_req = 1'b1;
        @(negedge clk);
        chk_reset_vals("por");
        inst_sram_req = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("por_rready_after", 32'(rready), 32'd1);

        // single read
        single_read(32'h1C00_0000, 32'h02C0_0000, 2'b00);
        chk("sr_bus_err", 32'(bus_err), 32'd0);

        // outstanding limit with req held high and delayed R beats
        tick();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1C00_0100;
        arready        = 1'b1;
        @(negedge clk);
        chk("os_ok0", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        inst_sram_addr = 32'h1C00_0104;
        @(negedge clk);
        chk("os_ok1", 32'(inst_sram_addr_ok), 32'd1);
        chk("os_araddr0", araddr, 32'h1C00_0100);
        tick();
        inst_sram_addr = 32'h1C00_0108;
        @(negedge clk);
        chk("os_full", 32'(inst_sram_addr_ok), 32'd0);
        chk("os_araddr1", araddr, 32'h1C00_0104);
        tick();
        rvalid = 1'b1;
        rdata  = 32'hA000_0000;
        @(negedge clk);
        chk("os_no_same_cycle_free", 32'(inst_sram_addr_ok), 32'd0);
        chk("os_arvalid_idle", 32'(arvalid), 32'd0);
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        chk("os_ok_after_r", 32'(inst_sram_addr_ok), 32'd1);
        chk("os_dok0", 32'(inst_sram_data_ok), 32'd1);
        chk("os_rdata0", inst_sram_rdata, 32'hA000_0000);
        tick();
        inst_sram_req = 1'b0;
        rvalid        = 1'b1;
        rdata         = 32'hA000_0001;
        @(negedge clk);
        chk("os_dok_gap", 32'(inst_sram_data_ok), 32'd0);
        chk("os_araddr2", araddr, 32'h1C00_0108);
        tick();
        rdata = 32'hA000_0002;
        @(negedge clk);
        chk("os_dok1", 32'(inst_sram_data_ok), 32'd1);
        chk("os_rdata1", inst_sram_rdata, 32'hA000_0001);
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        chk("os_dok2", 32'(inst_sram_data_ok), 32'd1);
        chk("os_rdata2", inst_sram_rdata, 32'hA000_0002);
        tick();
        @(negedge clk);
        chk("os_dok_end", 32'(inst_sram_data_ok), 32'd0);

        // arready held low for 5 cycles
        tick();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1C00_0200;
        arready        = 1'b0;
        @(negedge clk);
        chk("stall_accept0", 32'(inst_sram_addr_ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            inst_sram_addr = 32'h1C00_0204;
            @(negedge clk);
            chk("stall_arvalid", 32'(arvalid), 32'd1);
            chk("stall_araddr", araddr, 32'h1C00_0200);
            chk("stall_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        end
        tick();
        arready = 1'b1;
        @(negedge clk);
        chk("stall_accept1", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        inst_sram_req = 1'b0;
        @(negedge clk);
        chk("stall_arvalid1", 32'(arvalid), 32'd1);
        chk("stall_araddr1", araddr, 32'h1C00_0204);
        tick();
        rvalid = 1'b1;
        rdata  = 32'hB000_0000;
        @(negedge clk);
        chk("stall_ar_drop", 32'(arvalid), 32'd0);
        tick();
        rdata = 32'hB000_0001;
        @(negedge clk);
        chk("stall_dok0", 32'(inst_sram_data_ok), 32'd1);
        chk("stall_rdata0", inst_sram_rdata, 32'hB000_0000);
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        chk("stall_dok1", 32'(inst_sram_data_ok), 32'd1);
        chk("stall_rdata1", inst_sram_rdata, 32'hB000_0001);

        // error response is still returned and sets the sticky flag
        single_read(32'h1C00_0300, 32'hDEAD_BEEF, 2'b10);
        chk("slverr_bus_err", 32'(bus_err), 32'd1);
        single_read(32'h1C00_0304, 32'h1111_1111, 2'b00);
        chk("slverr_sticky", 32'(bus_err), 32'd1);

        // spurious beat with nothing in flight
        sync_reset();
        chk("sp_bus_err_clr", 32'(bus_err), 32'd0);
        tick();
        rvalid = 1'b1;
        rdata  = 32'h5555_5555;
        @(negedge clk);
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        chk("sp_no_dok", 32'(inst_sram_data_ok), 32'd0);
        chk("sp_rdata_kept", inst_sram_rdata, 32'd0);
        chk("sp_bus_err", 32'(bus_err), 32'd1);
        single_read(32'h1C00_0400, 32'h1234_5678, 2'b00);
        chk("sp_bus_err_sticky", 32'(bus_err), 32'd1);

        // asynchronous reset with two reads in flight
        tick();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1C00_0500;
        arready        = 1'b1;
        @(negedge clk);
        chk("ar_ok0", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        inst_sram_addr = 32'h1C00_0504;
        @(negedge clk);
        chk("ar_ok1", 32'(inst_sram_addr_ok), 32'd1);
        tick();
        inst_sram_req = 1'b0;
        #2;
        rstn          = 1'b0;
        inst_sram_req = 1'b1;
        #1;
        chk_reset_vals("arst_imm");
        tick();
        @(negedge clk);
        chk_reset_vals("arst_hold");
        tick();
        rstn          = 1'b1;
        inst_sram_req = 1'b0;
        @(negedge clk);
        single_read(32'h1C00_0000, 32'h02C0_0000, 2'b00);
        chk("arst_bus_err", 32'(bus_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
